// File: rtl/iob_cache_axi_pkg.sv
// iob_cache_axi_pkg: write-channel FSM states, AXI burst/response codes and line geometry helper
package iob_cache_axi_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  function automatic int beats_per_line(input int fe_w, input int be_w, input int off_w);
    return ((fe_w << off_w) >= be_w) ? (fe_w << off_w) / be_w : 1;
  endfunction
endpackage

// File: rtl/iob_cache_outstanding_cnt.sv
// iob_cache_outstanding_cnt: count of AW-issued writes awaiting B, saturating at MAX and never underflowing
module iob_cache_outstanding_cnt #(
  parameter int MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o
);
  logic inc_ok, dec_ok;
  assign inc_ok = inc_i && cnt_o != 4'(MAX);
  assign dec_ok = dec_i && cnt_o != 4'd0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_o <= '0;
    else if (inc_ok != dec_ok) cnt_o <= inc_ok ? cnt_o + 4'd1 : cnt_o - 4'd1;
endmodule

// File: rtl/iob_cache_write_channel_axi_mo.sv
// iob_cache_write_channel_axi_mo: cache write channel to AXI4 with write-through/write-back and multiple outstanding B
module iob_cache_write_channel_axi_mo
  import iob_cache_axi_pkg::*;
#(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int BE_DATA_W = 32,
  parameter int WORD_OFFSET_W = 2,
  parameter int WRITE_POL = 0,
  parameter int AXI_ID_W = 1,
  parameter int AXI_ID = 0,
  parameter int AXI_LEN_W = 8,
  parameter logic [3:0] CACHE_AXI_CACHE_MODE = 4'b0011,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [FE_ADDR_W-1:0]   addr_i,
  input  logic [(WRITE_POL ? FE_DATA_W*(2**WORD_OFFSET_W) : FE_DATA_W)-1:0] wdata_i,
  input  logic [FE_DATA_W/8-1:0] wstrb_i,
  output logic                   ready_o,
  output logic                   error_o,
  input  logic                   err_clr_i,
  output logic [3:0]             outstanding_o,
  output logic                   idle_o,
  output logic [AXI_ID_W-1:0]    awid_o,
  output logic [FE_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_LEN_W-1:0]   awlen_o,
  output logic [2:0]             awsize_o,
  output logic [1:0]             awburst_o,
  output logic                   awlock_o,
  output logic [3:0]             awcache_o,
  output logic [2:0]             awprot_o,
  output logic [3:0]             awqos_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [BE_DATA_W-1:0]   wdata_o,
  output logic [BE_DATA_W/8-1:0] wstrb_o,
  output logic                   wlast_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  input  logic [AXI_ID_W-1:0]    bid_i,
  input  logic [1:0]             bresp_i,
  input  logic                   bvalid_i,
  output logic                   bready_o
);
  localparam int WDATA_W = WRITE_POL ? FE_DATA_W * (2**WORD_OFFSET_W) : FE_DATA_W;
  localparam int FE_NB_W = $clog2(FE_DATA_W / 8);
  localparam int BE_NB_W = $clog2(BE_DATA_W / 8);
  localparam int AW_OFF = WRITE_POL ? FE_NB_W + WORD_OFFSET_W : FE_NB_W;
  localparam int BEATS = WRITE_POL ? beats_per_line(FE_DATA_W, BE_DATA_W, WORD_OFFSET_W) : 1;
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state, state_n;
  logic [FE_ADDR_W-1:0] addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic [FE_DATA_W/8-1:0] wstrb_q;
  logic [CNT_W-1:0] beat_q;
  logic accept, aw_hs, w_hs, b_hs;
  assign ready_o = state == IDLE && outstanding_o < 4'(MAX_OUTSTANDING);
  assign accept = valid_i && ready_o;
  assign awvalid_o = state == ADDR;
  assign wvalid_o = state == DATA;
  assign wlast_o = wvalid_o && beat_q == CNT_W'(BEATS - 1);
  assign aw_hs = awvalid_o && awready_i;
  assign w_hs = wvalid_o && wready_i;
  assign bready_o = outstanding_o != 4'd0;
  assign b_hs = bvalid_i && bready_o;
  assign idle_o = state == IDLE && outstanding_o == 4'd0;
  assign awid_o = AXI_ID_W'(AXI_ID);
  assign awaddr_o = (addr_q >> AW_OFF) << AW_OFF;
  assign awlen_o = AXI_LEN_W'(BEATS - 1);
  assign awsize_o = 3'(WRITE_POL ? BE_NB_W : FE_NB_W);
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o = 1'b0;
  assign awcache_o = CACHE_AXI_CACHE_MODE;
  assign awprot_o = 3'd0;
  assign awqos_o = 4'd0;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && accept) ? ADDR :
              (state == ADDR && awready_i) ? DATA :
              (state == DATA && wready_i && wlast_o) ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      beat_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      error_o <= 1'b0;
    end else begin
      state <= state_n;
      if (w_hs) beat_q <= wlast_o ? '0 : beat_q + 1'b1;
      if (accept) begin
        addr_q <= addr_i;
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      if (b_hs && bresp_i[1]) error_o <= 1'b1;
      else if (err_clr_i) error_o <= 1'b0;
    end
  // write-back streams the line lowest word first; write-through replicates one word into its lane
  if (WRITE_POL != 0) begin : g_wb
    assign wdata_o = wdata_q[beat_q*BE_DATA_W +: BE_DATA_W];
    assign wstrb_o = '1;
  end else begin : g_wt
    logic [BE_NB_W-1:0] lane_byte;
    assign lane_byte = addr_q[BE_NB_W-1:0] & ~BE_NB_W'((1 << FE_NB_W) - 1);
    assign wdata_o = {(BE_DATA_W / FE_DATA_W){wdata_q}};
    assign wstrb_o = (BE_DATA_W / 8)'(wstrb_q) << lane_byte;
  end
  iob_cache_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (aw_hs),
    .dec_i (b_hs),
    .cnt_o (outstanding_o)
  );
endmodule

// File: tb/tb_iob_cache_write_channel_axi_mo.sv
// tb_iob_cache_write_channel_axi_mo: directed vectors on write-through (32/64-bit AXI) and write-back instances
module tb_iob_cache_write_channel_axi_mo;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic sel = 0, t_valid = 0, c_valid = 0, awready = 0, wready = 0, bvalid = 0, err_clr = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wstrb = 0;
  logic [127:0] c_wdata_i = 0;
  logic [1:0] bresp = 0;
  logic [0:0] bid = 0;
  logic a_valid, b_valid;
  assign a_valid = t_valid & ~sel;
  assign b_valid = t_valid & sel;
  logic a_ready, a_error, a_idle, a_awvalid, a_wvalid, a_wlast, a_bready, a_awlock;
  logic b_ready, b_error, b_idle, b_awvalid, b_wvalid, b_wlast, b_bready, b_awlock;
  logic c_ready, c_error, c_idle, c_awvalid, c_wvalid, c_wlast, c_bready, c_awlock;
  logic [3:0] a_outst, a_awcache, a_awqos, a_wstrb_o, b_outst, b_awcache, b_awqos;
  logic [3:0] c_outst, c_awcache, c_awqos, c_wstrb_o;
  logic [31:0] a_awaddr, a_wdata_o, b_awaddr, c_awaddr, c_wdata_o;
  logic [63:0] b_wdata_o;
  logic [7:0] a_awlen, b_awlen, c_awlen, b_wstrb_o;
  logic [2:0] a_awsize, a_awprot, b_awsize, b_awprot, c_awsize, c_awprot;
  logic [1:0] a_awburst, b_awburst, c_awburst;
  logic [0:0] a_awid, b_awid, c_awid;

  iob_cache_write_channel_axi_mo #(.BE_DATA_W(32), .MAX_OUTSTANDING(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .addr_i(addr), .wdata_i(wdata),
    .wstrb_i(wstrb), .ready_o(a_ready), .error_o(a_error), .err_clr_i(err_clr),
    .outstanding_o(a_outst), .idle_o(a_idle), .awid_o(a_awid), .awaddr_o(a_awaddr),
    .awlen_o(a_awlen), .awsize_o(a_awsize), .awburst_o(a_awburst), .awlock_o(a_awlock),
    .awcache_o(a_awcache), .awprot_o(a_awprot), .awqos_o(a_awqos), .awvalid_o(a_awvalid),
    .awready_i(awready), .wdata_o(a_wdata_o), .wstrb_o(a_wstrb_o), .wlast_o(a_wlast),
    .wvalid_o(a_wvalid), .wready_i(wready), .bid_i(bid), .bresp_i(bresp),
    .bvalid_i(bvalid), .bready_o(a_bready));

  iob_cache_write_channel_axi_mo #(.BE_DATA_W(64)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .addr_i(addr), .wdata_i(wdata),
    .wstrb_i(wstrb), .ready_o(b_ready), .error_o(b_error), .err_clr_i(err_clr),
    .outstanding_o(b_outst), .idle_o(b_idle), .awid_o(b_awid), .awaddr_o(b_awaddr),
    .awlen_o(b_awlen), .awsize_o(b_awsize), .awburst_o(b_awburst), .awlock_o(b_awlock),
    .awcache_o(b_awcache), .awprot_o(b_awprot), .awqos_o(b_awqos), .awvalid_o(b_awvalid),
    .awready_i(awready), .wdata_o(b_wdata_o), .wstrb_o(b_wstrb_o), .wlast_o(b_wlast),
    .wvalid_o(b_wvalid), .wready_i(wready), .bid_i(bid), .bresp_i(bresp),
    .bvalid_i(bvalid), .bready_o(b_bready));

  iob_cache_write_channel_axi_mo #(.WRITE_POL(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid), .addr_i(addr), .wdata_i(c_wdata_i),
    .wstrb_i(wstrb), .ready_o(c_ready), .error_o(c_error), .err_clr_i(err_clr),
    .outstanding_o(c_outst), .idle_o(c_idle), .awid_o(c_awid), .awaddr_o(c_awaddr),
    .awlen_o(c_awlen), .awsize_o(c_awsize), .awburst_o(c_awburst), .awlock_o(c_awlock),
    .awcache_o(c_awcache), .awprot_o(c_awprot), .awqos_o(c_awqos), .awvalid_o(c_awvalid),
    .awready_i(awready), .wdata_o(c_wdata_o), .wstrb_o(c_wstrb_o), .wlast_o(c_wlast),
    .wvalid_o(c_wvalid), .wready_i(wready), .bid_i(bid), .bresp_i(bresp),
    .bvalid_i(bvalid), .bready_o(c_bready));

  logic m_ready, m_awvalid, m_wvalid, m_wlast, m_idle;
  logic [31:0] m_awaddr;
  logic [7:0] m_awlen, m_wstrb;
  logic [2:0] m_awsize;
  logic [63:0] m_wdata;
  logic [3:0] m_outst;
  always_comb begin
    m_ready = sel ? b_ready : a_ready;
    m_awvalid = sel ? b_awvalid : a_awvalid;
    m_wvalid = sel ? b_wvalid : a_wvalid;
    m_wlast = sel ? b_wlast : a_wlast;
    m_idle = sel ? b_idle : a_idle;
    m_awaddr = sel ? b_awaddr : a_awaddr;
    m_awlen = sel ? b_awlen : a_awlen;
    m_awsize = sel ? b_awsize : a_awsize;
    m_wdata = sel ? b_wdata_o : {32'h0, a_wdata_o};
    m_wstrb = sel ? b_wstrb_o : {4'h0, a_wstrb_o};
    m_outst = sel ? b_outst : a_outst;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  typedef struct {
    logic wide;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [31:0] exp_awaddr;
    logic [2:0] exp_awsize;
    logic [63:0] exp_wdata;
    logic [7:0] exp_wstrb;
  } vec_t;
  vec_t vecs[5];

  task automatic do_wt(input vec_t v);
    sel = v.wide; addr = v.addr; wdata = v.data; wstrb = v.strb;
    @(negedge clk); t_valid = 1;
    chk("wt_ready", m_ready, 1);
    @(negedge clk); t_valid = 0;
    chk("wt_awvalid", m_awvalid, 1);
    chk("wt_no_early_w", m_wvalid, 0);
    chk("wt_awaddr", m_awaddr, v.exp_awaddr);
    chk("wt_awlen", m_awlen, 0);
    chk("wt_awsize", m_awsize, v.exp_awsize);
    @(negedge clk);
    chk("wt_aw_hold", {m_awvalid, m_awaddr}, {1'b1, v.exp_awaddr});
    awready = 1;
    @(negedge clk); awready = 0;
    chk("wt_wvalid", {m_wvalid, m_awvalid}, 2'b10);
    chk("wt_wdata", m_wdata, v.exp_wdata);
    chk("wt_wstrb", m_wstrb, v.exp_wstrb);
    chk("wt_wlast", m_wlast, 1);
    chk("wt_outst_aw", m_outst, 1);
    wready = 1;
    @(negedge clk); wready = 0;
    chk("wt_w_done", {m_wvalid, m_idle}, 2'b00);
    bvalid = 1; bresp = 2'b00;
    @(negedge clk); bvalid = 0;
    chk("wt_outst_b", {m_outst, m_idle}, {4'd0, 1'b1});
  endtask

  task automatic a_push();
    sel = 0;
    @(negedge clk); t_valid = 1; awready = 1; wready = 1;
    @(negedge clk); t_valid = 0;
    @(negedge clk);
    @(negedge clk); awready = 0; wready = 0;
  endtask

  task automatic b_resp(input logic [1:0] r, input logic clr);
    @(negedge clk); bvalid = 1; bresp = r; err_clr = clr;
    @(negedge clk); bvalid = 0; err_clr = 0; bresp = 2'b00;
  endtask

  logic [31:0] wb_exp[4];
  int beat, seen;

  initial begin
    vecs[0] = '{1'b0, 32'h104, 32'hDEADBEEF, 4'hF, 32'h104, 3'd2, 64'hDEADBEEF, 8'h0F};
    vecs[1] = '{1'b0, 32'h107, 32'h12345678, 4'h2, 32'h104, 3'd2, 64'h12345678, 8'h02};
    vecs[2] = '{1'b1, 32'h104, 32'hDEADBEEF, 4'h3, 32'h104, 3'd2, 64'hDEADBEEF_DEADBEEF, 8'h30};
    vecs[3] = '{1'b1, 32'h200, 32'hCAFEF00D, 4'hC, 32'h200, 3'd2, 64'hCAFEF00D_CAFEF00D, 8'h0C};
    vecs[4] = '{1'b1, 32'h20E, 32'hA5A50001, 4'h1, 32'h20C, 3'd2, 64'hA5A50001_A5A50001, 8'h10};
    #12;
    chk("rst_a", {a_idle, a_ready, a_outst, a_error, a_awvalid, a_wvalid, a_wlast}, {2'b11, 4'd0, 4'b0000});
    chk("rst_c", {c_idle, c_ready, c_outst, c_error, c_awvalid, c_wvalid, c_wlast}, {2'b11, 4'd0, 4'b0000});
    chk("const_aw", {a_awid, a_awburst, a_awlock, a_awcache, a_awprot, a_awqos},
        {1'b0, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    @(negedge clk); rst_n = 1;
    foreach (vecs[i]) do_wt(vecs[i]);
    // pending-B limit, simultaneous AW/B, underflow guard
    a_push(); a_push();
    chk("full_outst", a_outst, 2);
    chk("full_ready", a_ready, 0);
    t_valid = 1;
    repeat (2) @(negedge clk);
    chk("full_no_accept", a_awvalid, 0);
    t_valid = 0;
    b_resp(2'b00, 0);
    chk("full_release", {a_outst, a_ready}, {4'd1, 1'b1});
    @(negedge clk); t_valid = 1;
    @(negedge clk); t_valid = 0; awready = 1; bvalid = 1;
    @(negedge clk); awready = 0; bvalid = 0;
    chk("aw_b_same_cycle", {a_outst, a_wvalid}, {4'd1, 1'b1});
    wready = 1;
    @(negedge clk); wready = 0;
    b_resp(2'b00, 0);
    chk("drain", a_outst, 0);
    chk("bready_zero", a_bready, 0);
    b_resp(2'b00, 0);
    chk("no_underflow", a_outst, 0);
    // sticky error
    a_push(); b_resp(2'b10, 0);
    chk("err_set", {a_error, a_outst}, {1'b1, 4'd0});
    a_push(); b_resp(2'b00, 0);
    chk("err_sticky", a_error, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_clr", a_error, 0);
    a_push(); b_resp(2'b11, 1);
    chk("err_set_wins", a_error, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    // write-back line burst with toggling wready
    for (int i = 0; i < 4; i++) wb_exp[i] = 32'hA0A0_0000 + i;
    c_wdata_i = {wb_exp[3], wb_exp[2], wb_exp[1], wb_exp[0]};
    addr = 32'h21C; wstrb = 4'hF;
    @(negedge clk); c_valid = 1;
    @(negedge clk); c_valid = 0;
    chk("wb_aw", {c_awvalid, c_wvalid, c_awaddr, c_awlen, c_awsize}, {2'b10, 32'h210, 8'd3, 3'd2});
    awready = 1;
    @(negedge clk); awready = 0;
    chk("wb_aw_done", c_awvalid, 0);
    beat = 0;
    for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
      wready = cyc % 2 == 1;
      if (c_wvalid) begin
        chk("wb_beat_data", c_wdata_o, wb_exp[beat]);
        chk("wb_beat_last", c_wlast, beat == 3);
        if (wready) begin
          chk("wb_wstrb", c_wstrb_o, 4'hF);
          beat++;
        end
      end
      @(negedge clk);
    end
    wready = 0;
    chk("wb_beats", beat, 4);
    chk("wb_end", {c_wvalid, c_outst}, {1'b0, 4'd1});
    b_resp(2'b00, 0);
    chk("wb_b", c_outst, 0);
    // reset during beat 2 of a write-back burst
    @(negedge clk); c_valid = 1;
    @(negedge clk); c_valid = 0; awready = 1;
    @(negedge clk); awready = 0; wready = 1;
    @(negedge clk); wready = 0;
    chk("wb_beat2", {c_wvalid, c_wdata_o}, {1'b1, wb_exp[1]});
    #2 rst_n = 0;
    #1;
    chk("rst_mid", {c_awvalid, c_wvalid, c_outst, c_idle, c_ready}, {2'b00, 4'd0, 2'b11});
    @(negedge clk); rst_n = 1; awready = 1; wready = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_awvalid || c_wvalid) seen++;
    end
    awready = 0; wready = 0;
    chk("no_residual", seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
